// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - line/beat geometry and adapter state shared with the arbiter and cache
package mem_if_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BEAT_WIDTH  = 64;
    localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
    localparam int OFFSET_BITS = 5;
    localparam int ADDR_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - 256-bit line port to 4-beat 64-bit burst memory adapter
module cacheline_adapter #(
    parameter int LINE_WIDTH = mem_if_pkg::LINE_WIDTH,
    parameter int BEAT_WIDTH = mem_if_pkg::BEAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LINE_WIDTH-1:0] line_i,
    output logic [LINE_WIDTH-1:0] line_o,
    input  logic [31:0]           address_i,
    input  logic                  read_i,
    input  logic                  write_i,
    output logic                  resp_o,
    input  logic [BEAT_WIDTH-1:0] burst_i,
    output logic [BEAT_WIDTH-1:0] burst_o,
    output logic [31:0]           address_o,
    output logic                  read_o,
    output logic                  write_o,
    input  logic                  resp_i
);

    import mem_if_pkg::adapter_state_t;
    import mem_if_pkg::IDLE;
    import mem_if_pkg::READ;
    import mem_if_pkg::WRITE;
    import mem_if_pkg::DONE;
    import mem_if_pkg::OFFSET_BITS;

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    adapter_state_t        r_state;
    adapter_state_t        w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [31:OFFSET_BITS] r_addr;
    logic [LINE_WIDTH-1:0] r_wline;
    logic [LINE_WIDTH-1:0] r_line;
    logic                  w_last_beat;
    logic                  w_unused_offset;

    // Line offset bits never reach memory: bursts always start on a line boundary.
    assign w_unused_offset = ^address_i[OFFSET_BITS-1:0];

    assign w_last_beat = resp_i && (r_cnt == LAST_BEAT);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: write wins over read so a dirty victim is written back before the fill.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_next_state = WRITE;
                end else if (read_i) begin
                    w_next_state = READ;
                end
            end
            READ: begin
                if (w_last_beat) begin
                    w_next_state = DONE;
                end
            end
            WRITE: begin
                if (w_last_beat) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request latching, beat counter and read-line assembly; inputs are frozen at acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wline <= '0;
            r_line  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (write_i) begin
                        r_addr  <= address_i[31:OFFSET_BITS];
                        r_wline <= line_i;
                    end else if (read_i) begin
                        r_addr  <= address_i[31:OFFSET_BITS];
                    end
                end
                READ: begin
                    if (resp_i) begin
                        r_line[r_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= burst_i;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign read_o    = (r_state == READ);
    assign write_o   = (r_state == WRITE);
    assign resp_o    = (r_state == DONE);
    assign address_o = {r_addr, {OFFSET_BITS{1'b0}}};
    assign burst_o   = (r_state == WRITE) ? r_wline[r_cnt*BEAT_WIDTH +: BEAT_WIDTH] : '0;
    assign line_o    = r_line;

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - directed self-checking bench for cacheline_adapter
module tb_cacheline_adapter;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] rd_line;
    logic [255:0] wr_line;
    logic [255:0] rd2_line;
    logic [255:0] wr2_line;
    logic [255:0] rd3_line;
    logic [255:0] rd4_line;
    logic [255:0] rd5_line;

    cacheline_adapter dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives n cycles of resp_i from pat; checks the strobe and, for writes, the beat on offer.
    task automatic run_beats(input bit is_read, input logic [255:0] data, input int n,
                             input logic [15:0] pat);
        int k;
        k = 0;
        for (int i = 0; i < n; i++) begin
            if (is_read) begin
                check("read_o_hold", read_o, 1'b1);
            end else begin
                check("write_o_hold", write_o, 1'b1);
                check("burst_o_beat", burst_o, data[k*64 +: 64]);
            end
            check("resp_o_low_in_burst", resp_o, 1'b0);
            resp_i  = pat[i];
            burst_i = is_read ? data[k*64 +: 64] : 64'h0;
            @(posedge clk); #1;
            if (pat[i]) k++;
        end
        resp_i  = 1'b0;
        burst_i = '0;
    endtask

    initial begin
        rst       = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;

        rd_line  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        wr_line  = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
        rd2_line = {64'hDDDD_0003_DDDD_0003, 64'hCCCC_0002_CCCC_0002,
                    64'hBBBB_0001_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
        wr2_line = {64'h5555_0003_5555_0003, 64'h6666_0002_6666_0002,
                    64'h7777_0001_7777_0001, 64'h8888_0000_8888_0000};
        rd3_line = {64'h9999_3333_9999_3333, 64'h9999_2222_9999_2222,
                    64'h9999_1111_9999_1111, 64'h9999_0000_9999_0000};
        rd4_line = {64'hA4A4_A4A4_0000_0003, 64'hA4A4_A4A4_0000_0002,
                    64'hA4A4_A4A4_0000_0001, 64'hA4A4_A4A4_0000_0000};
        rd5_line = {64'hB5B5_B5B5_0000_0003, 64'hB5B5_B5B5_0000_0002,
                    64'hB5B5_B5B5_0000_0001, 64'hB5B5_B5B5_0000_0000};

        // Reset state
        #2;
        check("rst_line_o", line_o, 256'h0);
        check("rst_burst_o", burst_o, 64'h0);
        check("rst_address_o", address_o, 32'h0);
        check("rst_read_o", read_o, 1'b0);
        check("rst_write_o", write_o, 1'b0);
        check("rst_resp_o", resp_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Plain read, back-to-back beats; address_i changes after acceptance
        read_i    = 1'b1;
        address_i = 32'h0000_1234;
        @(posedge clk); #1;
        read_i    = 1'b0;
        address_i = 32'hFFFF_FFFF;
        check("rd_address_o", address_o, 32'h0000_1220);
        check("rd_write_o_low", write_o, 1'b0);
        run_beats(1'b1, rd_line, 4, 16'h000F);
        check("rd_resp_o", resp_o, 1'b1);
        check("rd_read_o_done", read_o, 1'b0);
        check("rd_line_o", line_o, rd_line);
        @(posedge clk); #1;
        check("rd_resp_pulse_end", resp_o, 1'b0);
        check("rd_line_o_hold", line_o, rd_line);

        // Write with stalls; line_i and address_i change after acceptance
        line_i    = wr_line;
        address_i = 32'h0000_ABCD;
        write_i   = 1'b1;
        @(posedge clk); #1;
        write_i   = 1'b0;
        line_i    = '1;
        address_i = 32'h0;
        check("wr_address_o", address_o, 32'h0000_ABC0);
        check("wr_read_o_low", read_o, 1'b0);
        run_beats(1'b0, wr_line, 6, 16'b10_1101);
        check("wr_resp_o", resp_o, 1'b1);
        check("wr_write_o_done", write_o, 1'b0);
        check("wr_line_o_untouched", line_o, rd_line);
        @(posedge clk); #1;
        check("wr_resp_pulse_end", resp_o, 1'b0);

        // Read with stall pattern 1,0,0,1,0,1,1
        read_i    = 1'b1;
        address_i = 32'h8000_003F;
        @(posedge clk); #1;
        read_i    = 1'b0;
        check("stall_address_o", address_o, 32'h8000_0020);
        run_beats(1'b1, rd2_line, 7, 16'b110_1001);
        check("stall_resp_o", resp_o, 1'b1);
        check("stall_line_o", line_o, rd2_line);
        @(posedge clk); #1;
        check("stall_resp_pulse_end", resp_o, 1'b0);

        // Simultaneous read and write: write first, read held until IDLE
        line_i    = wr2_line;
        address_i = 32'h0000_0100;
        read_i    = 1'b1;
        write_i   = 1'b1;
        @(posedge clk); #1;
        write_i   = 1'b0;
        check("both_write_o_first", write_o, 1'b1);
        check("both_read_o_low", read_o, 1'b0);
        run_beats(1'b0, wr2_line, 4, 16'h000F);
        check("both_wr_resp_o", resp_o, 1'b1);
        check("both_read_ignored_done", read_o, 1'b0);
        @(posedge clk); #1;
        check("both_idle_read_o", read_o, 1'b0);
        check("both_idle_resp_o", resp_o, 1'b0);
        @(posedge clk); #1;
        read_i = 1'b0;
        check("both_read_accepted", read_o, 1'b1);
        check("both_read_address_o", address_o, 32'h0000_0100);
        run_beats(1'b1, rd3_line, 4, 16'h000F);
        check("both_rd_resp_o", resp_o, 1'b1);
        check("both_rd_line_o", line_o, rd3_line);
        @(posedge clk); #1;

        // Asynchronous reset after two read beats
        read_i    = 1'b1;
        address_i = 32'h0000_2000;
        @(posedge clk); #1;
        read_i  = 1'b0;
        resp_i  = 1'b1;
        burst_i = 64'hDEAD_0000_DEAD_0000;
        @(posedge clk); #1;
        burst_i = 64'hDEAD_0001_DEAD_0001;
        @(posedge clk); #1;
        resp_i  = 1'b0;
        burst_i = '0;
        check("mid_read_o_before_rst", read_o, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_read_o", read_o, 1'b0);
        check("arst_address_o", address_o, 32'h0);
        check("arst_line_o", line_o, 256'h0);
        check("arst_resp_o", resp_o, 1'b0);
        check("arst_write_o", write_o, 1'b0);
        check("arst_burst_o", burst_o, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        read_i    = 1'b1;
        address_i = 32'h0000_3000;
        @(posedge clk); #1;
        read_i = 1'b0;
        check("post_rst_address_o", address_o, 32'h0000_3000);
        run_beats(1'b1, rd4_line, 4, 16'h000F);
        check("post_rst_resp_o", resp_o, 1'b1);
        check("post_rst_line_o", line_o, rd4_line);

        // Back-to-back: read_i reasserted during DONE
        read_i    = 1'b1;
        address_i = 32'h0000_4000;
        @(posedge clk); #1;
        check("b2b_idle_read_o", read_o, 1'b0);
        check("b2b_idle_resp_o", resp_o, 1'b0);
        check("b2b_idle_line_o", line_o, rd4_line);
        @(posedge clk); #1;
        read_i = 1'b0;
        check("b2b_read_o", read_o, 1'b1);
        check("b2b_address_o", address_o, 32'h0000_4000);
        check("b2b_line_o_before_beat0", line_o, rd4_line);
        resp_i  = 1'b1;
        burst_i = rd5_line[63:0];
        @(posedge clk); #1;
        resp_i  = 1'b0;
        burst_i = '0;
        check("b2b_line_o_after_beat0", line_o, {rd4_line[255:64], rd5_line[63:0]});
        run_beats(1'b1, rd5_line >> 64, 3, 16'h0007);
        check("b2b_resp_o", resp_o, 1'b1);
        check("b2b_line_o", line_o, rd5_line);
        @(posedge clk); #1;
        check("b2b_resp_pulse_end", resp_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Sits directly downstream of the cache arbiter, between its 256-bit line port and the 64-bit burst physical-memory port.
- Converts one line read into a 4-beat burst read, assembling the beats into a 256-bit line.
- Converts one line write into a 4-beat burst write.
- Returns a single-cycle completion pulse to the arbiter.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits.
- BEAT_WIDTH, 64, memory data bus width in bits.
- BEATS, LINE_WIDTH/BEAT_WIDTH (4), beats per burst. Derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- line_i  input  256  line to write (arbiter mem_line_write).
- line_o  output  256  assembled read line (arbiter mem_line_read).
- address_i  input  32  line address from arbiter.
- read_i  input  1  line read request.
- write_i  input  1  line write request.
- resp_o  output  1  line transfer complete, one-cycle pulse.
- burst_i  input  64  read beat from memory.
- burst_o  output  64  write beat to memory.
- address_o  output  32  burst address to memory.
- read_o  output  1  burst read request.
- write_o  output  1  burst write request.
- resp_i  input  1  memory beat handshake; one beat transferred per cycle where it is high.

Behaviour:
- Reset (rst=0, asynchronous) applies regardless of state, including mid-burst:
  - state=IDLE, beat counter=0, line buffer=0.
  - line_o, burst_o, address_o = 0; read_o, write_o, resp_o = 0.
  - An in-flight burst is abandoned; memory must also be reset.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- States:
  - IDLE:
    - If write_i=1: latch address_i and line_i, go to WRITE.
    - Else if read_i=1: latch address_i, go to READ.
    - write_i has priority when both are high (writeback before fill).
  - READ:
    - read_o=1; address_o = {latched[31:5], 5'b0}.
    - On each cycle with resp_i=1: line buffer[cnt*64 +: 64] <= burst_i; cnt++.
    - On the 4th beat (cnt==3 and resp_i): go to DONE.
  - WRITE:
    - write_o=1; same aligned address_o; burst_o = latched_line[cnt*64 +: 64].
    - cnt++ on each cycle with resp_i=1.
    - On the 4th beat: go to DONE.
  - DONE:
    - resp_o=1 for exactly one cycle; read_o=write_o=0; cnt=0; go to IDLE.
    - read_i/write_i are ignored in DONE, giving the arbiter one cycle to drop its request.
- Beat order: beat 0 = line[63:0], ascending to beat 3 = line[255:192].
- Beats may be non-consecutive. resp_i=0 cycles stall the counter; address_o, read_o/write_o and burst_o hold.
- The 2-bit counter wraps 3->0 only on the final beat.
- line_o is valid from the DONE cycle and holds until the next READ overwrites its first beat. A WRITE does not modify it.
- address_o low 5 bits are always 0. address_i low bits are ignored.
- Changes on address_i/line_i during a burst have no effect; values are latched at acceptance.
- resp_i in IDLE or DONE is ignored.
- Minimum latency, request high in IDLE to resp_o: 1 (accept) + 4 beats + 1 (DONE) = 6 cycles with back-to-back resp_i.

Decomposition:
- Package mem_if_pkg:
  - LINE_WIDTH, BEAT_WIDTH, BEATS, OFFSET_BITS (=5) constants.
  - adapter_state_t enum {IDLE, READ, WRITE, DONE}.
- Shared with the arbiter and cache for line width.
- No sub-module required. The beat counter and line buffer are inline in a single always_ff with async-low reset.

Test Plan:
- Read burst: address_i=0x0000_1234, read_i=1; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive resp_i → address_o=0x0000_1220, read_o high 4 cycles, resp_o pulses once at cycle 6, line_o={0x44..,0x33..,0x22..,0x11..}.
- Write burst: line_i=256'h0123...CDEF, write_i=1 → burst_o presents line[63:0], [127:64], [191:128], [255:192] in order, advancing only on resp_i; write_o drops in DONE; resp_o pulses once.
- Stalled beats: read with resp_i pattern 1,0,0,1,0,1,1 → exactly 4 beats captured in the correct slots; resp_o one cycle after the last resp_i.
- Simultaneous request: read_i=write_i=1 in IDLE → WRITE serviced first; read accepted only after DONE→IDLE, with read_i still high.
- Reset mid-burst: rst=0 after 2 read beats → all outputs 0 immediately (asynchronous, no clk edge needed); after release, a new read completes normally with cnt starting at 0.
- Back-to-back: arbiter reasserts read_i in the DONE cycle → ignored in DONE, accepted in IDLE the next cycle; second line_o correct, first line unchanged until beat 0 of the second read.
